// File: rtl/dbg_bus_pkg.sv
// Shared types for the debug-bus master: FSM states, queued command and captured response.
package dbg_bus_pkg;

   localparam int DBG_ADDR_W = 15;
   localparam int DBG_DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RSP  = 2'd3
   } dbg_state_e;

   typedef struct packed {
      logic                  we;
      logic [DBG_ADDR_W-1:0] addr;
      logic [DBG_DATA_W-1:0] wdata;
   } dbg_cmd_t;

   typedef struct packed {
      logic                  err;
      logic [DBG_DATA_W-1:0] rdata;
   } dbg_rsp_t;

endpackage

// File: rtl/dbg_bus_master_chk.sv
// Protocol checker for dbg_bus_master: debug_rvalid_i is only legal while waiting for a response.
module dbg_bus_master_chk (
   input logic clk_i,
   input logic rst_i,
   input logic in_wait_i,
   input logic rvalid_i
);

   a_rvalid_in_wait : assert property (@(posedge clk_i) disable iff (rst_i) rvalid_i |-> in_wait_i)
      else $error("dbg_bus_master: debug_rvalid_i outside WAIT");

endmodule

// File: rtl/dbg_cmd_fifo.sv
// Synchronous command FIFO for the debug-bus master; head entry is visible combinationally.
module dbg_cmd_fifo
   import dbg_bus_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic     clk_i,
   input  logic     rst_i,
   input  logic     push_i,
   input  logic     pop_i,
   input  dbg_cmd_t wdata_i,
   output dbg_cmd_t rdata_o,
   output logic     full_o,
   output logic     empty_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   dbg_cmd_t         mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             do_push_s;
   logic             do_pop_s;

   assign do_push_s = push_i && !full_o;
   assign do_pop_s  = pop_i && !empty_o;
   assign full_o    = (count_r == CNT_W'(DEPTH));
   assign empty_o   = (count_r == {CNT_W{1'b0}});
   assign rdata_o   = mem_r[rd_ptr_r];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_r <= {PTR_W{1'b0}};
         rd_ptr_r <= {PTR_W{1'b0}};
         count_r  <= {CNT_W{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + 1'b1;
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + 1'b1;
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + 1'b1;
            2'b01:   count_r <= count_r - 1'b1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Entry storage.
   always_ff @(posedge clk_i) begin
      if (do_push_s) begin
         mem_r[wr_ptr_r] <= wdata_i;
      end
   end

endmodule

// File: rtl/dbg_bus_master.sv
// Debug-bus initiator: queues host commands and issues them one at a time on req/gnt/rvalid.
// Optional gnt timeout enabled by defining DBG_MASTER_TIMEOUT_EN.
module dbg_bus_master
   import dbg_bus_pkg::*;
#(
   parameter int ADDR_WIDTH  = DBG_ADDR_W,
   parameter int DATA_WIDTH  = DBG_DATA_W,
   parameter int CMD_DEPTH   = 4,
   parameter int TIMEOUT_CYC = 256
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_we_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  debug_req_o,
   input  logic                  debug_gnt_i,
   input  logic                  debug_rvalid_i,
   output logic [ADDR_WIDTH-1:0] debug_addr_o,
   output logic                  debug_we_o,
   output logic [DATA_WIDTH-1:0] debug_wdata_o,
   input  logic [DATA_WIDTH-1:0] debug_rdata_i,
   output logic                  busy_o
);

   // Command/response records are sized by the package, so the port widths must agree.
   if (ADDR_WIDTH != DBG_ADDR_W || DATA_WIDTH != DBG_DATA_W) begin : g_bad_width
      $error("dbg_bus_master: ADDR_WIDTH/DATA_WIDTH must match dbg_bus_pkg");
   end
   if (CMD_DEPTH < 2 || (CMD_DEPTH & (CMD_DEPTH - 1)) != 0) begin : g_bad_depth
      $error("dbg_bus_master: CMD_DEPTH must be a power of two >= 2");
   end
   if (TIMEOUT_CYC < 1) begin : g_bad_timeout
      $error("dbg_bus_master: TIMEOUT_CYC must be >= 1");
   end

   dbg_state_e state_r;
   dbg_state_e state_s;
   dbg_cmd_t   cmd_r;
   dbg_cmd_t   push_cmd_s;
   dbg_cmd_t   head_s;
   dbg_rsp_t   rsp_r;
   dbg_rsp_t   rsp_s;
   logic       full_s;
   logic       empty_s;
   logic       pop_s;
   logic       tmo_hit_s;

   assign push_cmd_s = '{we: cmd_we_i, addr: cmd_addr_i, wdata: cmd_wdata_i};

   dbg_cmd_fifo #(
      .DEPTH (CMD_DEPTH)
   ) u_fifo (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .push_i  (cmd_valid_i),
      .pop_i   (pop_s),
      .wdata_i (push_cmd_s),
      .rdata_o (head_s),
      .full_o  (full_s),
      .empty_o (empty_s)
   );

`ifdef DBG_MASTER_TIMEOUT_EN
   localparam int TMO_W = $clog2(TIMEOUT_CYC) + 1;

   logic [TMO_W-1:0] tmo_cnt_r;

   assign tmo_hit_s = (tmo_cnt_r == TMO_W'(TIMEOUT_CYC - 1));

   // Counts cycles spent in REQ; restarts whenever a new command enters REQ.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (pop_s) begin
         tmo_cnt_r <= {TMO_W{1'b0}};
      end else if (state_r == REQ) begin
         tmo_cnt_r <= tmo_cnt_r + 1'b1;
      end else begin
         tmo_cnt_r <= tmo_cnt_r;
      end
   end
`else
   assign tmo_hit_s = 1'b0;
`endif

   // Next-state, FIFO pop and response capture.
   always_comb begin
      state_s = state_r;
      pop_s   = 1'b0;
      rsp_s   = rsp_r;
      case (state_r)
         IDLE: begin
            if (!empty_s) begin
               pop_s   = 1'b1;
               state_s = REQ;
            end else begin
               state_s = IDLE;
            end
         end
         REQ: begin
            if (debug_gnt_i) begin
               state_s = WAIT;
            end else if (tmo_hit_s) begin
               state_s     = RSP;
               rsp_s.err   = 1'b1;
               rsp_s.rdata = {DBG_DATA_W{1'b0}};
            end else begin
               state_s = REQ;
            end
         end
         WAIT: begin
            if (debug_rvalid_i) begin
               state_s     = RSP;
               rsp_s.err   = 1'b0;
               rsp_s.rdata = cmd_r.we ? {DBG_DATA_W{1'b0}} : debug_rdata_i;
            end else begin
               state_s = WAIT;
            end
         end
         RSP: begin
            if (rsp_ready_i) begin
               state_s = IDLE;
            end else begin
               state_s = RSP;
            end
         end
         default: state_s = IDLE;
      endcase
   end

   // State, active command and held response registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         cmd_r   <= '{we: 1'b0, addr: {DBG_ADDR_W{1'b0}}, wdata: {DBG_DATA_W{1'b0}}};
         rsp_r   <= '{err: 1'b0, rdata: {DBG_DATA_W{1'b0}}};
      end else begin
         state_r <= state_s;
         cmd_r   <= pop_s ? head_s : cmd_r;
         rsp_r   <= rsp_s;
      end
   end

   assign cmd_ready_o   = !full_s;
   assign debug_req_o   = (state_r == REQ);
   assign debug_addr_o  = cmd_r.addr;
   assign debug_we_o    = cmd_r.we;
   assign debug_wdata_o = cmd_r.wdata;
   assign rsp_valid_o   = (state_r == RSP);
   assign rsp_rdata_o   = rsp_r.rdata;
   assign rsp_err_o     = rsp_r.err;
   assign busy_o        = !empty_s || (state_r != IDLE);

   dbg_bus_master_chk u_chk (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .in_wait_i (state_r == WAIT),
      .rvalid_i  (debug_rvalid_i)
   );

endmodule

// File: tb/tb_dbg_bus_master.sv
// Self-checking bench for dbg_bus_master: cycle vector table plus directed multi-cycle sequences.
module tb_dbg_bus_master;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic        cmd_we = 1'b0;
   logic [14:0] cmd_addr = 15'h0;
   logic [31:0] cmd_wdata = 32'h0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        debug_req;
   logic        debug_gnt = 1'b0;
   logic        debug_rvalid = 1'b0;
   logic [14:0] debug_addr;
   logic        debug_we;
   logic [31:0] debug_wdata;
   logic [31:0] debug_rdata = 32'h0;
   logic        busy;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   dbg_bus_master #(
      .ADDR_WIDTH  (15),
      .DATA_WIDTH  (32),
      .CMD_DEPTH   (4),
      .TIMEOUT_CYC (16)
   ) dut (
      .clk_i          (clk),
      .rst_i          (rst),
      .cmd_valid_i    (cmd_valid),
      .cmd_ready_o    (cmd_ready),
      .cmd_we_i       (cmd_we),
      .cmd_addr_i     (cmd_addr),
      .cmd_wdata_i    (cmd_wdata),
      .rsp_valid_o    (rsp_valid),
      .rsp_ready_i    (rsp_ready),
      .rsp_rdata_o    (rsp_rdata),
      .rsp_err_o      (rsp_err),
      .debug_req_o    (debug_req),
      .debug_gnt_i    (debug_gnt),
      .debug_rvalid_i (debug_rvalid),
      .debug_addr_o   (debug_addr),
      .debug_we_o     (debug_we),
      .debug_wdata_o  (debug_wdata),
      .debug_rdata_i  (debug_rdata),
      .busy_o         (busy)
   );

   typedef struct {
      logic        v;
      logic        we;
      logic [14:0] addr;
      logic [31:0] wd;
      logic        gnt;
      logic        rv;
      logic [31:0] rd;
      logic        rrdy;
      logic        e_rdy;
      logic        e_req;
      logic        e_we;
      logic [14:0] e_addr;
      logic [31:0] e_wd;
      logic        e_rv;
      logic [31:0] e_rdata;
      logic        e_busy;
   } vec_t;

   localparam int NV = 13;
   vec_t vecs [NV];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic push(input logic [14:0] a, input logic we, input logic [31:0] wd);
      check("push_ready", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b1;
      cmd_we    = we;
      cmd_addr  = a;
      cmd_wdata = wd;
      tick();
      cmd_valid = 1'b0;
   endtask

   // Waits (bounded) for req, then completes one transaction with immediate gnt and rvalid.
   task automatic serve(input logic [14:0] a, input logic we, input logic [31:0] rd);
      int n = 0;
      while (!debug_req && n < 20) begin
         tick();
         n++;
      end
      check("serve_req_seen", 32'(debug_req), 32'd1);
      check("serve_addr", 32'(debug_addr), 32'(a));
      check("serve_we", 32'(debug_we), 32'(we));
      debug_gnt = 1'b1;
      tick();
      debug_gnt = 1'b0;
      check("serve_req_drop", 32'(debug_req), 32'd0);
      debug_rvalid = 1'b1;
      debug_rdata  = rd;
      tick();
      debug_rvalid = 1'b0;
      check("serve_rsp_valid", 32'(rsp_valid), 32'd1);
      check("serve_rdata", rsp_rdata, we ? 32'd0 : rd);
      check("serve_err", 32'(rsp_err), 32'd0);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("serve_rsp_done", 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      // Cycle table: inputs applied for one edge, outputs expected after that edge.
      vecs[0]  = '{1'b1, 1'b1, 15'h0010, 32'h0001_0000, 1'b0, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b0, 1'b0, 15'h0000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[1]  = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b1, 1'b1, 15'h0010, 32'h0001_0000, 1'b0, 32'h0, 1'b1};
      vecs[2]  = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b0, 1'b1, 15'h0010, 32'h0001_0000, 1'b0, 32'h0, 1'b1};
      vecs[3]  = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b0, 1'b1, 32'h1234_5678, 1'b0,
                   1'b1, 1'b0, 1'b1, 15'h0010, 32'h0001_0000, 1'b1, 32'h0, 1'b1};
      vecs[4]  = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                   1'b1, 1'b0, 1'b1, 15'h0010, 32'h0001_0000, 1'b0, 32'h0, 1'b0};
      vecs[5]  = '{1'b1, 1'b0, 15'h2000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b0, 1'b1, 15'h0010, 32'h0001_0000, 1'b0, 32'h0, 1'b1};
      vecs[6]  = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b1, 1'b0, 15'h2000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[7]  = vecs[6];
      vecs[8]  = vecs[6];
      vecs[9]  = vecs[6];
      vecs[10] = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b1, 1'b0, 32'h0, 1'b0,
                   1'b1, 1'b0, 1'b0, 15'h2000, 32'h0, 1'b0, 32'h0, 1'b1};
      vecs[11] = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0,
                   1'b1, 1'b0, 1'b0, 15'h2000, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1};
      vecs[12] = '{1'b0, 1'b0, 15'h0000, 32'h0, 1'b0, 1'b0, 32'h0, 1'b1,
                   1'b1, 1'b0, 1'b0, 15'h2000, 32'h0, 1'b0, 32'hDEAD_BEEF, 1'b0};

      // Reset values.
      #2 rst = 1'b1;
      #6;
      check("rst_ready", 32'(cmd_ready), 32'd1);
      check("rst_req", 32'(debug_req), 32'd0);
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_rdata", rsp_rdata, 32'd0);
      check("rst_err", 32'(rsp_err), 32'd0);
      check("rst_addr", 32'(debug_addr), 32'd0);
      #14 rst = 1'b0;
      tick();

      // Write with gnt in req cycle, then read with gnt delayed 3 cycles.
      for (int i = 0; i < NV; i++) begin
         cmd_valid    = vecs[i].v;
         cmd_we       = vecs[i].we;
         cmd_addr     = vecs[i].addr;
         cmd_wdata    = vecs[i].wd;
         debug_gnt    = vecs[i].gnt;
         debug_rvalid = vecs[i].rv;
         debug_rdata  = vecs[i].rd;
         rsp_ready    = vecs[i].rrdy;
         tick();
         check($sformatf("vec%0d_ready", i), 32'(cmd_ready), 32'(vecs[i].e_rdy));
         check($sformatf("vec%0d_req", i), 32'(debug_req), 32'(vecs[i].e_req));
         check($sformatf("vec%0d_we", i), 32'(debug_we), 32'(vecs[i].e_we));
         check($sformatf("vec%0d_addr", i), 32'(debug_addr), 32'(vecs[i].e_addr));
         check($sformatf("vec%0d_wdata", i), debug_wdata, vecs[i].e_wd);
         check($sformatf("vec%0d_rsp_valid", i), 32'(rsp_valid), 32'(vecs[i].e_rv));
         check($sformatf("vec%0d_rdata", i), rsp_rdata, vecs[i].e_rdata);
         check($sformatf("vec%0d_err", i), 32'(rsp_err), 32'd0);
         check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      end
      cmd_valid = 1'b0; debug_gnt = 1'b0; debug_rvalid = 1'b0; rsp_ready = 1'b0;

      // Fill the FIFO with gnt withheld: 1 popped, 4 queued, sixth blocked until next pop.
      for (int i = 0; i < 5; i++) begin
         check("fill_ready", 32'(cmd_ready), 32'd1);
         cmd_valid = 1'b1;
         cmd_we    = 1'b0;
         cmd_addr  = 15'h0100 + 15'(i);
         cmd_wdata = 32'h0;
         tick();
      end
      check("full_ready", 32'(cmd_ready), 32'd0);
      check("full_req", 32'(debug_req), 32'd1);
      check("full_head_addr", 32'(debug_addr), 32'h0100);
      cmd_addr = 15'h0105;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("full_hold_ready", 32'(cmd_ready), 32'd0);
         check("full_hold_req", 32'(debug_req), 32'd1);
      end
      debug_gnt = 1'b1;
      tick();
      debug_gnt    = 1'b0;
      debug_rvalid = 1'b1;
      debug_rdata  = 32'h0000_00A5;
      tick();
      debug_rvalid = 1'b0;
      check("full_rsp_rdata", rsp_rdata, 32'h0000_00A5);
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("full_idle_ready", 32'(cmd_ready), 32'd0);
      tick();
      check("pop_ready", 32'(cmd_ready), 32'd1);
      check("pop_req", 32'(debug_req), 32'd1);
      check("pop_addr", 32'(debug_addr), 32'h0101);
      tick();
      cmd_valid = 1'b0;
      check("refill_ready", 32'(cmd_ready), 32'd0);
      serve(15'h0101, 1'b0, 32'h1111_0101);
      serve(15'h0102, 1'b0, 32'h1111_0102);
      serve(15'h0103, 1'b0, 32'h1111_0103);
      serve(15'h0104, 1'b0, 32'h1111_0104);
      serve(15'h0105, 1'b0, 32'h1111_0105);
      check("drain_busy", 32'(busy), 32'd0);

      // Response held for 10 cycles with two commands queued behind it.
      push(15'h0200, 1'b0, 32'h0);
      push(15'h0201, 1'b0, 32'h0);
      push(15'h0202, 1'b1, 32'h0000_7777);
      check("hold_first_addr", 32'(debug_addr), 32'h0200);
      debug_gnt = 1'b1;
      tick();
      debug_gnt    = 1'b0;
      debug_rvalid = 1'b1;
      debug_rdata  = 32'hCAFE_0001;
      tick();
      debug_rvalid = 1'b0;
      for (int i = 0; i < 10; i++) begin
         check("hold_rsp_valid", 32'(rsp_valid), 32'd1);
         check("hold_rdata", rsp_rdata, 32'hCAFE_0001);
         check("hold_no_req", 32'(debug_req), 32'd0);
         check("hold_busy", 32'(busy), 32'd1);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      rsp_ready = 1'b0;
      check("hold_release_valid", 32'(rsp_valid), 32'd0);
      check("hold_release_no_req", 32'(debug_req), 32'd0);
      tick();
      check("hold_next_req", 32'(debug_req), 32'd1);
      serve(15'h0201, 1'b0, 32'h2222_0201);
      serve(15'h0202, 1'b1, 32'hFFFF_FFFF);

      // Asynchronous reset while waiting for rvalid, with another command queued.
      push(15'h0300, 1'b1, 32'h0000_0055);
      push(15'h0301, 1'b0, 32'h0);
      debug_gnt = 1'b1;
      tick();
      debug_gnt = 1'b0;
      check("arst_pre_busy", 32'(busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_req", 32'(debug_req), 32'd0);
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_ready", 32'(cmd_ready), 32'd1);
      check("arst_addr", 32'(debug_addr), 32'd0);
      #3 rst = 1'b0;
      tick();
      check("arst_post_busy", 32'(busy), 32'd0);
      tick();
      check("arst_post_req", 32'(debug_req), 32'd0);
      check("arst_post_busy2", 32'(busy), 32'd0);

`ifdef DBG_MASTER_TIMEOUT_EN
      // gnt never arrives: req lasts TIMEOUT_CYC cycles, then an error response.
      begin
         int n = 0;
         int w = 0;
         push(15'h0400, 1'b0, 32'h0);
         while (!debug_req && w < 10) begin
            tick();
            w++;
         end
         while (debug_req && n < 100) begin
            tick();
            n++;
         end
         check("tmo_req_cycles", 32'(n), 32'd16);
         check("tmo_rsp_valid", 32'(rsp_valid), 32'd1);
         check("tmo_err", 32'(rsp_err), 32'd1);
         check("tmo_rdata", rsp_rdata, 32'd0);
         rsp_ready = 1'b1;
         tick();
         rsp_ready = 1'b0;
         check("tmo_done", 32'(rsp_valid), 32'd0);
         check("tmo_busy", 32'(busy), 32'd0);
      end
`else
      // Without the timeout, req waits indefinitely for gnt.
      begin
         int held = 0;
         push(15'h0400, 1'b0, 32'h0);
         tick();
         for (int i = 0; i < 40; i++) begin
            if (debug_req) begin
               held++;
            end
            tick();
         end
         check("notmo_req_held", 32'(held), 32'd40);
         check("notmo_err", 32'(rsp_err), 32'd0);
         serve(15'h0400, 1'b0, 32'h0BAD_F00D);
         check("notmo_busy", 32'(busy), 32'd0);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
